shift_arbiter: RTL and testbench

- Shares one 16-bit shifter datapath between NUM_REQ independent requesters, e.g. the EX-stage ALU port and the load byte-alignment path.
- Each requester has a valid/ready handshake.
- Arbitration is round-robin.
- A 2-stage registered pipeline (issue register, then result register) returns the shifted value with the winner's ID on a single response channel with backpressure.

---
 rtl/shift_pkg.sv | 18 +
 rtl/rr_arb.sv | 28 ++
 rtl/shift_unit.sv | 20 ++
 rtl/shift_arbiter.sv | 118 +++++++++++
 tb/tb_shift_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter slice.
package shift_pkg;
  localparam int SHIFT_W = 16;
  localparam int AMT_W   = 4;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRA = 2'b01,
    ROR = 2'b10,
    ILL = 2'b11
  } shift_mode_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] data;
    logic [AMT_W-1:0]   amt;
    shift_mode_t        mode;
  } shift_req_t;
endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = IDX_W'(c);
        gnt[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shift_unit.sv
// Shared 16-bit shifter datapath: SLL, SRA, ROR; illegal mode yields zero.
module shift_unit
  import shift_pkg::*;
(
  input  shift_req_t         req,
  output logic [SHIFT_W-1:0] res
);
  logic [2*SHIFT_W-1:0] rot;

  always_comb begin
    rot = {req.data, req.data} >> req.amt;
    res = '0;
    case (req.mode)
      SLL:     res = req.data << req.amt;
      SRA:     res = $signed(req.data) >>> req.amt;
      ROR:     res = rot[SHIFT_W-1:0];
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared shifter: issue register (s1) then result register (rsp).
// Define SHIFT_ARB_PERF_EN to add grant/stall performance counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]   req_amt,
  input  logic [NUM_REQ*2-1:0]       req_mode,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SHIFT_W-1:0]         rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_err
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]      perf_grant_cnt,
  output logic [15:0]                perf_stall_cnt
`endif
);
  logic               s1_valid;
  shift_req_t         s1_req;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    rr_ptr;
  logic               adv1, adv2, any, xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win, ptr_nxt;
  shift_req_t         win_req;
  logic [SHIFT_W-1:0] sh_res;

  assign adv2 = !rsp_valid || rsp_ready;
  assign adv1 = !s1_valid || adv2;

  rr_arb #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // Ready stays low during reset so nothing is accepted into a clearing pipe.
  assign req_ready = (adv1 && !rst) ? gnt : '0;
  assign xfer      = any && adv1 && !rst;
  assign ptr_nxt   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  always_comb begin
    int w;
    w            = int'(win);
    win_req.data = req_data[SHIFT_W*w +: SHIFT_W];
    win_req.amt  = req_amt[AMT_W*w +: AMT_W];
    win_req.mode = shift_mode_t'(req_mode[2*w +: 2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (adv1) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_req <= win_req;
        s1_id  <= win;
        rr_ptr <= ptr_nxt;
      end
    end
  end

  shift_unit u_shift (
    .req (s1_req),
    .res (sh_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= sh_res;
        rsp_id   <= s1_id;
        rsp_err  <= (s1_req.mode == ILL);
      end
    end
  end

`ifdef SHIFT_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        grant_cnt[g] <= '0;
      else if (req_valid[g] && req_ready[g] && grant_cnt[g] != 16'hFFFF)
        grant_cnt[g] <= grant_cnt[g] + 16'd1;
    end
  end
  assign perf_grant_cnt = grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (rsp_valid && !rsp_ready && perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (NUM_REQ=2, perf counters off).
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_data = '0;
  logic [7:0]  req_amt = '0;
  logic [3:0]  req_mode = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [0:0]  rsp_id;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  shift_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [15:0] d,
                         input logic [3:0] a, input logic [1:0] m);
    req_valid[i]         = v;
    req_data[16*i +: 16] = d;
    req_amt[4*i +: 4]    = a;
    req_mode[2*i +: 2]   = m;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h id=%b err=%b, want 0/0000/0/0",
               rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0001, 4'd4, 2'b00);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency_n1: rsp_valid got %b want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0010 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got v=%b d=%h id=%b e=%b want 1/0010/0/0",
               rsp_valid, rsp_data, rsp_id, rsp_err);
    end
  endtask

  task automatic test_modes();
    logic [15:0] vd [9] = '{16'h8000, 16'h1234, 16'hA5A5, 16'hA5A5, 16'hA5A5,
                            16'h4000, 16'h8001, 16'h0001, 16'h00F0};
    logic [3:0]  va [9] = '{4'd15, 4'd4, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd1, 4'd8};
    logic [1:0]  vm [9] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [15:0] ve [9] = '{16'hFFFF, 16'h4123, 16'hA5A5, 16'hA5A5, 16'hA5A5,
                            16'h0800, 16'h0002, 16'h8000, 16'hF000};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, vd[k], va[k], vm[k]);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ve[k] || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL mode_vec%0d: got v=%b d=%h e=%b want 1/%h/0", k, rsp_valid, rsp_data,
                 rsp_err, ve[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy;
    logic [15:0] exp_d;
    int          id;
    pulse_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 7) begin
        id    = (c - 2) % 2;
        exp_d = (id == 1) ? 16'(16'h0100 + c - 2) : 16'(c - 2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== id[0] || rsp_data !== exp_d) begin
          failures++;
          $display("FAIL b2b_rsp_c%0d: got v=%b id=%b d=%h want 1/%0d/%h", c, rsp_valid,
                   rsp_id, rsp_data, id, exp_d);
        end
      end else if (c == 8) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_drain: rsp_valid got %b want 0", rsp_valid);
        end
      end
      if (c < 6) begin
        set_req(0, 1'b1, 16'(c), 4'd0, 2'b00);
        set_req(1, 1'b1, 16'(16'h0100 + c), 4'd0, 2'b01);
        #1;
        exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (req_ready !== exp_rdy) begin
          failures++;
          $display("FAIL b2b_grant_c%0d: got %b want %b", c, req_ready, exp_rdy);
        end
      end else begin
        req_valid = '0;
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0A00, 4'd0, 2'b00);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_accept0: got %b want 01", req_ready);
    end
    @(negedge clk);
    set_req(0, 1'b1, 16'h0B00, 4'd0, 2'b00);
    #1;
    checks++;
    if (req_ready !== 2'b01 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept1: got rdy=%b v=%b want 01/0", req_ready, rsp_valid);
    end
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(0, 1'b1, 16'h0C00, 4'd0, 2'b00);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h0A00 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold_c%0d: got v=%b d=%h id=%b rdy=%b want 1/0a00/0/00", c,
                 rsp_valid, rsp_data, rsp_id, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01 || rsp_data !== 16'h0A00) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b d=%h want 01/0a00", req_ready, rsp_data);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0B00) begin
      failures++;
      $display("FAIL bp_drain1: got v=%b d=%h want 1/0b00", rsp_valid, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0C00) begin
      failures++;
      $display("FAIL bp_drain2: got v=%b d=%h want 1/0c00", rsp_valid, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain_end: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_req(1, 1'b1, 16'hFFFF, 4'd3, 2'b11);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL ill_grant: got %b want 10", req_ready);
    end
    @(negedge clk);
    set_req(1, 1'b1, 16'h0001, 4'd1, 2'b00);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || rsp_err !== 1'b1 || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL ill_result: got v=%b d=%h e=%b id=%b want 1/0000/1/1", rsp_valid,
               rsp_data, rsp_err, rsp_id);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002 || rsp_err !== 1'b0 || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL ill_next_legal: got v=%b d=%h e=%b id=%b want 1/0002/0/1", rsp_valid,
               rsp_data, rsp_err, rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h1111, 4'd0, 2'b00);
    set_req(1, 1'b1, 16'h2222, 4'd0, 2'b00);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_full: rsp_valid got %b want 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL rmid_async: got v=%b d=%h rdy=%b want 0/0000/00", rsp_valid, rsp_data,
               req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h3333, 4'd0, 2'b00);
    set_req(1, 1'b1, 16'h4444, 4'd0, 2'b00);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rmid_ptr: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_stale: rsp_valid got %b want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h3333) begin
      failures++;
      $display("FAIL rmid_first: got v=%b id=%b d=%h want 1/0/3333", rsp_valid, rsp_id,
               rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_end: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
